entrada_operandos: RTL
======================

Name: entrada_operandos

Overview:
- Upstream input stage for the 4-bit ALU (`ULA`) and its 7-segment display path on the DE-board.
- Turns raw switches and push-buttons into a stable operand/operation set: operand A, then operand B, then the operation code, each committed by one button press.
- Outputs drive the ALU's `numum`/`numdois`/`sel` inputs directly; `valido` marks a complete, consistent set.

Parameters:
- LARGURA, 4, operand width in bits (matches the ALU operands).
- DEBOUNCE_CICLOS, 250000, consecutive stable-low cycles required to accept a press (5 ms at 50 MHz); counter width = $clog2(DEBOUNCE_CICLOS+1).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- sw_dado  input  LARGURA  operand switches, quasi-static, sampled on commit.
- sw_sel  input  3  operation-select switches, sampled on commit.
- key_confirma  input  1  raw push-button, active-low, asynchronous to clk.
- key_cancela  input  1  raw push-button, active-low, asynchronous to clk.
- numum  output  LARGURA  committed operand A.
- numdois  output  LARGURA  committed operand B.
- sel  output  3  committed operation code.
- valido  output  1  high while in EXIBE (full set committed).
- erro  output  1  one-cycle pulse on a rejected operation code.
- estado  output  2  current FSM state, for LED display.

Behaviour:
- Reset (async assert, sync release):
  - numum, numdois and sel = 0; valido = 0; erro = 0; estado = ESPERA_A (2'b00).
  - Synchronisers, debounce counters and edge detectors cleared to the "released" state.
- Each key: 2-FF synchroniser → debounce filter → falling-edge detector, giving a one-cycle press event per physical press. Releasing the key produces no event.
- Debounce filter:
  - Counter increments while the synchronised key is low and clears to 0 on any high sample.
  - The filtered level goes low when the counter reaches DEBOUNCE_CICLOS and saturates there.
  - The filtered level goes high on the first high sample.
- Latency: committed outputs update on the (DEBOUNCE_CICLOS+3)th rising edge after the key is first sampled low, provided the key is held low throughout.
- FSM states, with transitions on a confirma event:
  - ESPERA_A (00): numum ← sw_dado; go to ESPERA_B.
  - ESPERA_B (01): numdois ← sw_dado; go to ESPERA_OP.
  - ESPERA_OP (10): if sw_sel ≤ 3'b101, sel ← sw_sel and go to EXIBE. Otherwise pulse erro for 1 cycle, keep sel unchanged and stay in ESPERA_OP.
  - EXIBE (11): go to ESPERA_A. numum, numdois and sel hold their values until overwritten.
- A cancela event in any state goes to ESPERA_A and leaves committed values unchanged.
- If cancela and confirma events occur in the same cycle, cancela wins and confirma is discarded.
- valido is registered: high exactly while estado == EXIBE, and falls in the same edge that leaves EXIBE.
- Holding a key produces a single event; a new event requires release and then re-debounce.
- Glitches shorter than DEBOUNCE_CICLOS produce no event.
- Reset mid-debounce or mid-sequence discards all progress and returns to the reset values.

Optional Feature:
- Macro: ENTRADA_DEBOUNCE_EN.
- Defined: debounce filter present as described above.
- Undefined:
  - Filter removed; the edge detector takes the 2-FF synchroniser output directly.
  - Outputs update on the 3rd rising edge after the key is first sampled low.
  - Bounce produces multiple events. This mode is for simulation and fast benches only.
- DEBOUNCE_CICLOS is ignored when the macro is undefined.

Decomposition:
- Shared package ula_pkg:
  - State enum: ESPERA_A, ESPERA_B, ESPERA_OP, EXIBE.
  - Operation constants: OP_AND 000, OP_OR 001, OP_SOMA 010, OP_SUB 011, OP_MUL2 100, OP_DIV2 101.
  - OP_MAX = 3'b101.
- One sub-module, filtro_botao: synchroniser + optional debounce + falling-edge pulse.
  - Instantiated twice, once for confirma and once for cancela.
  - Parameterised by DEBOUNCE_CICLOS.

Test Plan (ENTRADA_DEBOUNCE_EN defined, DEBOUNCE_CICLOS=4):
- Reset, then three clean presses with sw_dado=4'd3, sw_dado=4'd5, sw_sel=3'b010 → numum=3, numdois=5, sel=010, valido=1, estado=11. Each update lands exactly 7 edges after the key is first sampled low.
- Key low for 3 cycles, then high (glitch) → no event; estado stays 00 and numum stays 0.
- In ESPERA_OP with sw_sel=3'b110 pressed → erro high for exactly 1 cycle, estado stays 10, sel unchanged. A following press with sw_sel=3'b001 → sel=001, estado=11.
- From ESPERA_B, both keys pressed in the same cycle → estado=00; numum keeps its previous value; numdois not written.
- Key held low for 50 cycles in ESPERA_A → exactly one commit, estado=01, no second advance.
- rst_n asserted mid-debounce during ESPERA_OP, with outputs holding 7/2/100 → all outputs 0 immediately (async). After release, no phantom event even though the key is still held low.

Source files
------------

// File: rtl/ula_pkg.sv
// Shared definitions for the ALU input stage: FSM states and operation codes.
package ula_pkg;

  typedef enum logic [1:0] {
    ESPERA_A  = 2'b00,
    ESPERA_B  = 2'b01,
    ESPERA_OP = 2'b10,
    EXIBE     = 2'b11
  } estado_e;

  localparam logic [2:0] OP_AND  = 3'b000;
  localparam logic [2:0] OP_OR   = 3'b001;
  localparam logic [2:0] OP_SOMA = 3'b010;
  localparam logic [2:0] OP_SUB  = 3'b011;
  localparam logic [2:0] OP_MUL2 = 3'b100;
  localparam logic [2:0] OP_DIV2 = 3'b101;
  localparam logic [2:0] OP_MAX  = OP_DIV2;

  // True when the code names an operation the ALU implements.
  function automatic logic op_valida(input logic [2:0] op);
    return op <= OP_MAX;
  endfunction

endpackage

// File: rtl/filtro_botao.sv
// Push-button conditioner: 2-FF synchroniser, optional debounce, one-cycle
// registered press event on the falling edge of the filtered level.
// ENTRADA_DEBOUNCE_EN defined   : debounce filter of DEBOUNCE_CICLOS samples.
// ENTRADA_DEBOUNCE_EN undefined : synchroniser output used directly.
// A key held through reset never produces an event until it is released once.
module filtro_botao #(
  parameter int unsigned DEBOUNCE_CICLOS = 250000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_i,
  output logic evento_o
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CICLOS + 1);

  logic [1:0] sinc_q;
  logic [1:0] rdy_q;
  logic       armado_q, armado_d;
  logic       evento_q, evento_d;
  logic       nivel_q, nivel_d;

`ifdef ENTRADA_DEBOUNCE_EN
  logic [CW-1:0] cnt_q, cnt_d;
  logic          filt_q, filt_d;

  // Debounce: count stable-low samples, drop the level once the count is reached.
  always_comb begin
    cnt_d  = cnt_q;
    filt_d = filt_q;
    if (sinc_q[1]) begin
      cnt_d  = '0;
      filt_d = 1'b1;
    end else begin
      if (cnt_q < CW'(DEBOUNCE_CICLOS)) cnt_d = cnt_q + CW'(1);
      if (cnt_d == CW'(DEBOUNCE_CICLOS)) filt_d = 1'b0;
    end
  end

  // Debounce counter and filtered level registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      filt_q <= 1'b1;
    end else begin
      cnt_q  <= cnt_d;
      filt_q <= filt_d;
    end
  end

  assign nivel_q = filt_q;
  assign nivel_d = filt_d;
`else
  logic [CW-1:0] unused_cfg;
  assign unused_cfg = CW'(DEBOUNCE_CICLOS);

  assign nivel_q = sinc_q[1];
  assign nivel_d = sinc_q[0];
`endif

  // Arm only after a genuine released sample; press event on high-to-low level.
  always_comb begin
    armado_d = armado_q | (rdy_q[1] & sinc_q[1]);
    evento_d = armado_q & nivel_q & ~nivel_d;
  end

  // Synchroniser, sample-valid tracker, arm flag and event register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sinc_q   <= 2'b11;
      rdy_q    <= 2'b00;
      armado_q <= 1'b0;
      evento_q <= 1'b0;
    end else begin
      sinc_q   <= {sinc_q[0], key_i};
      rdy_q    <= {rdy_q[0], 1'b1};
      armado_q <= armado_d;
      evento_q <= evento_d;
    end
  end

  assign evento_o = evento_q;

endmodule

// File: rtl/entrada_operandos.sv
// Input stage for the 4-bit ALU: commits operand A, operand B and the
// operation code with successive confirma presses; cancela restarts.
// Optional debounce in the key conditioners: ENTRADA_DEBOUNCE_EN.
module entrada_operandos
  import ula_pkg::*;
#(
  parameter int unsigned LARGURA         = 4,
  parameter int unsigned DEBOUNCE_CICLOS = 250000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [LARGURA-1:0] sw_dado,
  input  logic [2:0]         sw_sel,
  input  logic               key_confirma,
  input  logic               key_cancela,
  output logic [LARGURA-1:0] numum,
  output logic [LARGURA-1:0] numdois,
  output logic [2:0]         sel,
  output logic               valido,
  output logic               erro,
  output logic [1:0]         estado
);

  logic confirma_ev;
  logic cancela_ev;

  filtro_botao #(.DEBOUNCE_CICLOS(DEBOUNCE_CICLOS)) u_confirma (
    .clk      (clk),
    .rst_n    (rst_n),
    .key_i    (key_confirma),
    .evento_o (confirma_ev)
  );

  filtro_botao #(.DEBOUNCE_CICLOS(DEBOUNCE_CICLOS)) u_cancela (
    .clk      (clk),
    .rst_n    (rst_n),
    .key_i    (key_cancela),
    .evento_o (cancela_ev)
  );

  estado_e            state_q, state_d;
  logic [LARGURA-1:0] numum_q, numum_d;
  logic [LARGURA-1:0] numdois_q, numdois_d;
  logic [2:0]         sel_q, sel_d;
  logic               valido_q, valido_d;
  logic               erro_q, erro_d;

  // Next state and committed values; cancela overrides a simultaneous confirma.
  always_comb begin
    state_d   = state_q;
    numum_d   = numum_q;
    numdois_d = numdois_q;
    sel_d     = sel_q;
    erro_d    = 1'b0;
    if (cancela_ev) begin
      state_d = ESPERA_A;
    end else if (confirma_ev) begin
      case (state_q)
        ESPERA_A: begin
          numum_d = sw_dado;
          state_d = ESPERA_B;
        end
        ESPERA_B: begin
          numdois_d = sw_dado;
          state_d   = ESPERA_OP;
        end
        ESPERA_OP: begin
          if (op_valida(sw_sel)) begin
            sel_d   = sw_sel;
            state_d = EXIBE;
          end else begin
            erro_d = 1'b1;
          end
        end
        EXIBE: begin
          state_d = ESPERA_A;
        end
      endcase
    end
    valido_d = (state_d == EXIBE);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ESPERA_A;
      numum_q   <= '0;
      numdois_q <= '0;
      sel_q     <= '0;
      valido_q  <= 1'b0;
      erro_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      numum_q   <= numum_d;
      numdois_q <= numdois_d;
      sel_q     <= sel_d;
      valido_q  <= valido_d;
      erro_q    <= erro_d;
    end
  end

  assign numum   = numum_q;
  assign numdois = numdois_q;
  assign sel     = sel_q;
  assign valido  = valido_q;
  assign erro    = erro_q;
  assign estado  = state_q;

endmodule
